rom_access_arbiter: RTL and testbench

//   Shares the single 128x8 program ROM between two read requesters: port A (CPU instruction

---
 rtl/rom_arb_pkg.sv | 18 +
 rtl/rr_arbiter_2.sv | 46 ++++
 rtl/rom_access_arbiter.sv | 147 ++++++++++++++
 tb/tb_rom_access_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and widths for the program-ROM access arbiter.
package rom_arb_pkg;

  localparam int ROM_AW = 7;
  localparam int ROM_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_id_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester arbiter: round-robin or fixed A priority, with a last-winner
// register that only advances when the caller strobes update.
module rr_arbiter_2
  import rom_arb_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  output logic win_b,
  output logic any_req
);

  port_id_t last_winner_q;
  port_id_t last_winner_d;
  port_id_t winner;

  always_comb begin
    winner = PORT_A;
    if (req_a && req_b) begin
      // On a tie the port that did not win last time goes first.
      if ((FIXED_PRI != 0) || (last_winner_q == PORT_B)) begin
        winner = PORT_A;
      end else begin
        winner = PORT_B;
      end
    end else if (req_b) begin
      winner = PORT_B;
    end
    any_req       = req_a | req_b;
    win_b         = (winner == PORT_B);
    last_winner_d = update ? winner : last_winner_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_winner_q <= PORT_B;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one synchronous-read program ROM between the CPU fetch port (A) and
// the debug/table-lookup port (B), one access at a time.
//
//   state  | meaning
//   IDLE   | sample requests, latch winner's address on a win
//   ACCESS | ROM_LAT+1 cycles; gnt in first cycle, rom_data captured at last edge
//   DONE   | rvalid pulse to the winner, requests ignored
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AW        = ROM_AW,
  parameter int DW        = ROM_DW,
  parameter int ROM_LAT   = 0,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic [AW-1:0] rom_address,
  input  logic [DW-1:0] rom_data,
  output logic          busy
);

  localparam int CW = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ROM_LAT);

  arb_state_t    state_q, state_d;
  port_id_t      winner_q, winner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          a_gnt_q, a_gnt_d;
  logic          b_gnt_q, b_gnt_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;

  logic arb_update;
  logic arb_win_b;
  logic arb_any_req;

  rr_arbiter_2 #(
    .FIXED_PRI(FIXED_PRI)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_a  (a_req),
    .req_b  (b_req),
    .update (arb_update),
    .win_b  (arb_win_b),
    .any_req(arb_any_req)
  );

  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    arb_update = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_any_req) begin
          arb_update = 1'b1;
          winner_d   = arb_win_b ? PORT_B : PORT_A;
          addr_d     = arb_win_b ? b_addr : a_addr;
          cnt_d      = '0;
          a_gnt_d    = !arb_win_b;
          b_gnt_d    = arb_win_b;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          if (winner_q == PORT_B) begin
            b_rdata_d  = rom_data;
            b_rvalid_d = 1'b1;
          end else begin
            a_rdata_d  = rom_data;
            a_rvalid_d = 1'b1;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset abandons any access in flight: the pending rvalid is simply lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      winner_q   <= PORT_A;
      addr_q     <= '0;
      cnt_q      <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  assign a_gnt       = a_gnt_q;
  assign b_gnt       = b_gnt_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign rom_address = addr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter: instance 0 is ROM_LAT=0 round-robin, instance 1 is
// ROM_LAT=1 fixed-priority with a registered ROM model; both checked against a timestamped scoreboard.
module tb_rom_access_arbiter;
  import rom_arb_pkg::*;

  localparam int QN    = 64;
  localparam int T_END = 615;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n, a_req, b_req, a_gnt, b_gnt, a_rvalid, b_rvalid, busy;
  logic [1:0][6:0] a_addr, b_addr, rom_address;
  logic [1:0][7:0] a_rdata, b_rdata, rom_data;
  logic [7:0]      rom_mem [128];
  logic [7:0]      rom_q1;

  initial begin
    for (int k = 0; k < 128; k++) rom_mem[k] = 8'((k * 29 + 7) ^ (k >> 2));
    rom_mem[0] = 8'h86;
    rom_mem[1] = 8'hAA;
    rom_mem[3] = 8'hF0;
    rom_mem[5] = 8'h00;
  end

  assign rom_data[0] = rom_mem[rom_address[0]];
  always @(posedge clk) rom_q1 <= rom_mem[rom_address[1]];
  assign rom_data[1] = rom_q1;

  rom_access_arbiter #(.ROM_LAT(0), .FIXED_PRI(0)) dut0 (
    .clk(clk), .reset(rst_n[0]),
    .a_req(a_req[0]), .a_addr(a_addr[0]), .a_gnt(a_gnt[0]), .a_rdata(a_rdata[0]), .a_rvalid(a_rvalid[0]),
    .b_req(b_req[0]), .b_addr(b_addr[0]), .b_gnt(b_gnt[0]), .b_rdata(b_rdata[0]), .b_rvalid(b_rvalid[0]),
    .rom_address(rom_address[0]), .rom_data(rom_data[0]), .busy(busy[0])
  );

  rom_access_arbiter #(.ROM_LAT(1), .FIXED_PRI(1)) dut1 (
    .clk(clk), .reset(rst_n[1]),
    .a_req(a_req[1]), .a_addr(a_addr[1]), .a_gnt(a_gnt[1]), .a_rdata(a_rdata[1]), .a_rvalid(a_rvalid[1]),
    .b_req(b_req[1]), .b_addr(b_addr[1]), .b_gnt(b_gnt[1]), .b_rdata(b_rdata[1]), .b_rvalid(b_rvalid[1]),
    .rom_address(rom_address[1]), .rom_data(rom_data[1]), .busy(busy[1])
  );

  // Reference model: instance i has ROM_LAT = i; instance 1 uses fixed A priority.
  int         cyc = 0;
  int         prev_cyc;
  int         busy_until [2] = '{-1, -1};
  logic       last_b [2] = '{1'b1, 1'b1};
  logic [6:0] exp_addr [2] = '{7'd0, 7'd0};
  int         wa [2] = '{0, 0};
  int         wb [2] = '{0, 0};
  int         qa_g [2][QN];
  int         qa_v [2][QN];
  logic [7:0] qa_d [2][QN];
  int         qb_g [2][QN];
  int         qb_v [2][QN];
  logic [7:0] qb_d [2][QN];
  logic       win_b;
  logic [6:0] w_addr;

  initial begin
    forever begin
      @(posedge clk);
      prev_cyc = cyc;
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n[i]) begin
          busy_until[i] = -1;
          last_b[i]     = 1'b1;
          exp_addr[i]   = 7'd0;
        end else if (prev_cyc > busy_until[i] && (a_req[i] || b_req[i])) begin
          win_b         = b_req[i] && (!a_req[i] || (i == 0 && !last_b[i]));
          w_addr        = win_b ? b_addr[i] : a_addr[i];
          exp_addr[i]   = w_addr;
          last_b[i]     = win_b;
          busy_until[i] = cyc + i + 1;
          if (win_b) begin
            qb_g[i][wb[i]] = cyc;
            qb_v[i][wb[i]] = cyc + i + 1;
            qb_d[i][wb[i]] = rom_mem[w_addr];
            wb[i] = (wb[i] + 1) % QN;
          end else begin
            qa_g[i][wa[i]] = cyc;
            qa_v[i][wa[i]] = cyc + i + 1;
            qa_d[i][wa[i]] = rom_mem[w_addr];
            wa[i] = (wa[i] + 1) % QN;
          end
        end
      end
    end
  end

  int         n_chk = 0;
  int         n_pass = 0;
  int         ra [2] = '{0, 0};
  int         rb [2] = '{0, 0};
  logic [7:0] exp_ad [2] = '{8'd0, 8'd0};
  logic [7:0] exp_bd [2] = '{8'd0, 8'd0};
  logic       ea_g, eb_g, ea_v, eb_v;

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d cyc=%0d actual=%0h expected=%0h", nm, i, cyc, act, exp);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n[i]) begin
          ra[i] = wa[i];
          rb[i] = wb[i];
          exp_ad[i] = 8'd0;
          exp_bd[i] = 8'd0;
        end
        ea_g = (ra[i] != wa[i]) && (qa_g[i][ra[i]] == cyc);
        ea_v = (ra[i] != wa[i]) && (qa_v[i][ra[i]] == cyc);
        eb_g = (rb[i] != wb[i]) && (qb_g[i][rb[i]] == cyc);
        eb_v = (rb[i] != wb[i]) && (qb_v[i][rb[i]] == cyc);
        if (ea_v) begin
          exp_ad[i] = qa_d[i][ra[i]];
          ra[i] = (ra[i] + 1) % QN;
        end
        if (eb_v) begin
          exp_bd[i] = qb_d[i][rb[i]];
          rb[i] = (rb[i] + 1) % QN;
        end
        chk("a_gnt", i, int'(a_gnt[i]), int'(ea_g));
        chk("b_gnt", i, int'(b_gnt[i]), int'(eb_g));
        chk("a_rvalid", i, int'(a_rvalid[i]), int'(ea_v));
        chk("b_rvalid", i, int'(b_rvalid[i]), int'(eb_v));
        chk("a_rdata", i, int'(a_rdata[i]), int'(exp_ad[i]));
        chk("b_rdata", i, int'(b_rdata[i]), int'(exp_bd[i]));
        chk("busy", i, int'(busy[i]), int'(rst_n[i] && (cyc <= busy_until[i])));
        chk("rom_address", i, int'(rom_address[i]), rst_n[i] ? int'(exp_addr[i]) : 0);
      end
    end
  end

  int mid_st [2] = '{0, 0};

  task automatic drive(input int i, input int t);
    if (t < 3 || (t >= 15 && t < 17)) begin
      rst_n[i] = 1'b0;
      a_req[i] = 1'b0;
      b_req[i] = 1'b0;
    end else if (t < 15) begin
      rst_n[i] = 1'b1;
      if (t == 3) begin
        if (i == 0) begin a_req[i] = 1'b1; a_addr[i] = 7'd0; end
        else        begin b_req[i] = 1'b1; b_addr[i] = 7'd3; end
      end else begin
        if (a_gnt[i]) a_req[i] = 1'b0;
        if (b_gnt[i]) b_req[i] = 1'b0;
      end
    end else if (t < 47) begin
      rst_n[i]  = 1'b1;
      a_req[i]  = 1'b1;
      b_req[i]  = 1'b1;
      a_addr[i] = 7'd1;
      b_addr[i] = 7'd5;
    end else if (t == 47) begin
      a_req[i] = 1'b0;
      b_req[i] = 1'b0;
    end else if (t < 75) begin
      case (mid_st[i])
        0: begin
          if (a_gnt[i]) begin rst_n[i] = 1'b0; mid_st[i] = 1; end
          a_req[i]  = 1'b1;
          a_addr[i] = 7'd2;
        end
        1: mid_st[i] = 2;
        2: begin rst_n[i] = 1'b1; mid_st[i] = 3; end
        3: if (a_gnt[i]) begin a_req[i] = 1'b0; mid_st[i] = 4; end
        default: ;
      endcase
    end else if (t < 600) begin
      rst_n[i] = !(t >= 400 && t < 402);
      if (a_req[i] && a_gnt[i]) begin
        a_req[i]  = ($urandom_range(0, 1) == 1);
        a_addr[i] = 7'($urandom_range(0, 127));
      end else if (!a_req[i]) begin
        a_req[i]  = ($urandom_range(0, 2) == 0);
        a_addr[i] = 7'($urandom_range(0, 127));
      end
      if (b_req[i] && b_gnt[i]) begin
        b_req[i]  = ($urandom_range(0, 1) == 1);
        b_addr[i] = 7'($urandom_range(0, 127));
      end else if (!b_req[i]) begin
        b_req[i]  = ($urandom_range(0, 2) == 0);
        b_addr[i] = 7'($urandom_range(0, 127));
      end
    end else begin
      rst_n[i] = 1'b1;
      a_req[i] = 1'b0;
      b_req[i] = 1'b0;
    end
  endtask

  initial begin
    rst_n  = '0;
    a_req  = '0;
    b_req  = '0;
    a_addr = '0;
    b_addr = '0;
    for (int t = 0; t < T_END; t++) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) drive(i, t);
    end
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
